// File: rtl/tq_ram_sp_param.sv
// ============================================================================
//  Module   : tq_ram_sp_param
//  Purpose  : Parametrised single-port RAM for TQ coefficient/scratch storage
//             with per-bit write mask, optional output register, read-valid
//             strobe and a post-reset zero-fill sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tq_ram_sp_param #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int OUT_REG    = 0,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic [WORD_WIDTH-1:0] bwen_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        c_ST_INIT  = 1'b0,
        c_ST_READY = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = (INIT_ZERO != 0) ? c_ST_INIT : c_ST_READY;

    state_t                  r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   r_fill_cnt_q, w_fill_cnt_d;
    logic                    r_rd_vld_q, w_rd_vld_d;
    logic [WORD_WIDTH-1:0]   r_rd_data_q, w_rd_data_d;

    logic [WORD_WIDTH-1:0]   r_mem_q [c_DEPTH];

    logic                    w_mem_we;
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [WORD_WIDTH-1:0]   w_mem_bwen;
    logic [WORD_WIDTH-1:0]   w_mem_din;
    logic [WORD_WIDTH-1:0]   w_mem_wdata;

    // The fill sequencer owns the array pins while in INIT; user inputs are dropped.
    always_comb begin
        w_state_d    = r_state_q;
        w_fill_cnt_d = r_fill_cnt_q;
        w_mem_we     = 1'b0;
        w_rd_en      = 1'b0;
        w_mem_addr   = addr_i;
        w_mem_bwen   = bwen_i;
        w_mem_din    = data_i;
        case (r_state_q)
            c_ST_INIT: begin
                w_mem_we     = 1'b1;
                w_mem_addr   = r_fill_cnt_q;
                w_mem_bwen   = '0;
                w_mem_din    = '0;
                w_fill_cnt_d = r_fill_cnt_q + ADDR_WIDTH'(1);
                if (r_fill_cnt_q == c_LAST_ADDR) begin
                    w_state_d = c_ST_READY;
                end
            end
            c_ST_READY: begin
                w_mem_we = ~cen_i & ~wen_i;
                w_rd_en  = ~cen_i &  wen_i;
            end
            default: w_state_d = c_RST_STATE;
        endcase
        // Mask bits are active low: a 0 lets the new data bit through.
        w_mem_wdata = (r_mem_q[w_mem_addr] & w_mem_bwen) | (w_mem_din & ~w_mem_bwen);
        w_rd_vld_d  = w_rd_en;
        w_rd_data_d = w_rd_en ? r_mem_q[addr_i] : r_rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_RST_STATE;
            r_fill_cnt_q <= '0;
            r_rd_vld_q   <= 1'b0;
            r_rd_data_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_fill_cnt_q <= w_fill_cnt_d;
            r_rd_vld_q   <= w_rd_vld_d;
            r_rd_data_q  <= w_rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem_q[w_mem_addr] <= w_mem_wdata;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_out_vld_q, w_out_vld_d;
            logic [WORD_WIDTH-1:0] r_out_data_q, w_out_data_d;

            always_comb begin
                w_out_vld_d  = r_rd_vld_q;
                w_out_data_d = r_rd_vld_q ? r_rd_data_q : r_out_data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_vld_q  <= 1'b0;
                    r_out_data_q <= '0;
                end else begin
                    r_out_vld_q  <= w_out_vld_d;
                    r_out_data_q <= w_out_data_d;
                end
            end

            assign data_o  = r_out_data_q;
            assign valid_o = r_out_vld_q;
        end else begin : g_no_out_reg
            assign data_o  = r_rd_data_q;
            assign valid_o = r_rd_vld_q;
        end
    endgenerate

    assign busy_o = (r_state_q == c_ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_tq_ram_sp_param.sv
// ============================================================================
//  Module   : tb_tq_ram_sp_param
//  Purpose  : Directed self-checking bench; drives one latency-1 and one
//             latency-2 instance with identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tq_ram_sp_param;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_cen;
    logic        r_wen;
    logic [15:0] r_bwen;
    logic [4:0]  r_addr;
    logic [15:0] r_data;
    logic [15:0] w_data0, w_data1;
    logic        w_valid0, w_valid1;
    logic        w_busy0, w_busy1;

    int total = 0;
    int bad   = 0;

    logic [4:0]  ra [0:31];
    logic [15:0] re [0:31];

    always #5 clk = ~clk;

    tq_ram_sp_param #(.WORD_WIDTH(16), .ADDR_WIDTH(5), .OUT_REG(0), .INIT_ZERO(1)) u_dut0 (
        .clk(clk), .rst(r_rst), .cen_i(r_cen), .wen_i(r_wen), .bwen_i(r_bwen),
        .addr_i(r_addr), .data_i(r_data), .data_o(w_data0), .valid_o(w_valid0), .busy_o(w_busy0)
    );

    tq_ram_sp_param #(.WORD_WIDTH(16), .ADDR_WIDTH(5), .OUT_REG(1), .INIT_ZERO(1)) u_dut1 (
        .clk(clk), .rst(r_rst), .cen_i(r_cen), .wen_i(r_wen), .bwen_i(r_bwen),
        .addr_i(r_addr), .data_i(r_data), .data_o(w_data1), .valid_o(w_valid1), .busy_o(w_busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        r_cen  = 1'b1;
        r_wen  = 1'b1;
        r_bwen = 16'hFFFF;
    endtask

    task automatic do_reset;
        idle();
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        check_val("rst_data0", {16'h0, w_data0}, 32'h0);
        check_val("rst_data1", {16'h0, w_data1}, 32'h0);
        check_val("rst_valid", {30'h0, w_valid0, w_valid1}, 32'h0);
        check_val("rst_busy", {30'h0, w_busy0, w_busy1}, 32'h3);
    endtask

    // Runs the fill while hammering both DUTs with writes/reads to address 7.
    task automatic wait_fill;
        int n  = 0;
        int vs = 0;
        while (w_busy0 && n < 100) begin
            r_cen  = 1'b0;
            r_wen  = n[0];
            r_addr = 5'd7;
            r_data = 16'hFFFF;
            r_bwen = 16'h0000;
            tick();
            if (w_valid0 || w_valid1) vs++;
            if (w_busy0 !== w_busy1) vs++;
            n++;
        end
        idle();
        check_val("fill_cycles", n, 32);
        check_val("busy_no_valid", vs, 0);
    endtask

    task automatic write_word(input logic [4:0] a, input logic [15:0] d, input logic [15:0] m);
        r_cen  = 1'b0;
        r_wen  = 1'b0;
        r_addr = a;
        r_data = d;
        r_bwen = m;
        tick();
        check_val("wr_no_valid", {30'h0, w_valid0, w_valid1}, 32'h0);
        idle();
    endtask

    // Back-to-back reads of ra[0..n-1]; checks latency, strobe and hold for both DUTs.
    task automatic read_burst(input int n);
        for (int t = 0; t < n + 3; t++) begin
            if (t < n) begin
                r_cen  = 1'b0;
                r_wen  = 1'b1;
                r_addr = ra[t];
            end else begin
                idle();
            end
            tick();
            check_val($sformatf("rd0_v%0d", t), {31'h0, w_valid0}, {31'h0, (t < n)});
            check_val($sformatf("rd0_d%0d", t), {16'h0, w_data0}, {16'h0, re[(t < n) ? t : n - 1]});
            check_val($sformatf("rd1_v%0d", t), {31'h0, w_valid1}, {31'h0, (t >= 1 && t <= n)});
            if (t >= 1) begin
                check_val($sformatf("rd1_d%0d", t), {16'h0, w_data1},
                          {16'h0, re[(t - 1 < n) ? t - 1 : n - 1]});
            end
        end
    endtask

    initial begin
        r_rst  = 1'b1;
        r_addr = '0;
        r_data = '0;
        idle();
        tick();

        // Fill after reset, then sweep all addresses; address 7 was poked during busy.
        do_reset();
        wait_fill();
        for (int i = 0; i < 32; i++) begin
            ra[i] = 5'(i);
            re[i] = 16'h0000;
        end
        read_burst(32);

        // Per-bit masked write.
        write_word(5'd3, 16'hA5A5, 16'h0000);
        write_word(5'd3, 16'h1234, 16'hFF00);
        ra[0] = 5'd3; re[0] = 16'hA534;
        read_burst(1);

        // Three consecutive reads with distinct words.
        write_word(5'd0, 16'h1111, 16'h0000);
        write_word(5'd1, 16'h2222, 16'h0000);
        write_word(5'd2, 16'h3333, 16'h0000);
        ra[0] = 5'd0; re[0] = 16'h1111;
        ra[1] = 5'd1; re[1] = 16'h2222;
        ra[2] = 5'd2; re[2] = 16'h3333;
        read_burst(3);

        // Write-then-read at the top address, then cen_i=1 cycles.
        write_word(5'd31, 16'hBEEF, 16'h0000);
        ra[0] = 5'd31; re[0] = 16'hBEEF;
        read_burst(1);
        for (int i = 0; i < 3; i++) begin
            r_cen = 1'b1;
            r_wen = i[0];
            tick();
            check_val("cen_hi_valid", {30'h0, w_valid0, w_valid1}, 32'h0);
        end

        // Reset mid-fill restarts it; an in-flight read is discarded.
        write_word(5'd5, 16'hFFFF, 16'h0000);
        r_cen = 1'b0; r_wen = 1'b1; r_addr = 5'd5;
        tick();
        check_val("pre_rst_rd0", {16'h0, w_data0}, 32'h0000FFFF);
        do_reset();
        tick();
        check_val("inflight_drop", {30'h0, w_valid0, w_valid1}, 32'h0);
        for (int i = 0; i < 9; i++) tick();
        check_val("midfill_busy", {30'h0, w_busy0, w_busy1}, 32'h3);
        do_reset();
        wait_fill();
        ra[0] = 5'd5; re[0] = 16'h0000;
        ra[1] = 5'd7; re[1] = 16'h0000;
        ra[2] = 5'd31; re[2] = 16'h0000;
        read_burst(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
